// File: rtl/cpu_op_pkg.sv
// Shared definitions for the CPU operation interface: opcode width, opcodes and sequencer states.
package cpu_op_pkg;
    localparam int OP_W = 4;

    localparam logic [OP_W-1:0] OP_NOP   = 4'h0;
    localparam logic [OP_W-1:0] OP_ADD   = 4'h1;
    localparam logic [OP_W-1:0] OP_SUB   = 4'h2;
    localparam logic [OP_W-1:0] OP_AND   = 4'h3;
    localparam logic [OP_W-1:0] OP_OR    = 4'h4;
    localparam logic [OP_W-1:0] OP_XOR   = 4'h5;
    localparam logic [OP_W-1:0] OP_SHL   = 4'h6;
    localparam logic [OP_W-1:0] OP_SHR   = 4'h7;
    localparam logic [OP_W-1:0] OP_LOAD  = 4'h8;
    localparam logic [OP_W-1:0] OP_STORE = 4'h9;
    localparam logic [OP_W-1:0] OP_JMP   = 4'hA;
    localparam logic [OP_W-1:0] OP_HALT  = 4'hF;

    // Program terminator; the sequencer never presents it to the CPU.
    localparam logic [OP_W-1:0] HALT_OP = OP_HALT;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } seq_state_e;
endpackage

// File: rtl/cpu_op_prog_mem.sv
// Program store for the sequencer: register array, synchronous write, two asynchronous read ports.
module cpu_op_prog_mem #(
    parameter int DEPTH = 16,
    parameter int OP_W  = 4,
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic            clock,
    input  logic            wr_en,
    input  logic [AW-1:0]   wr_addr,
    input  logic [OP_W-1:0] wr_data,
    input  logic [AW-1:0]   rd_addr_a,
    output logic [OP_W-1:0] rd_data_a,
    input  logic [AW-1:0]   rd_addr_b,
    output logic [OP_W-1:0] rd_data_b
);
    logic [OP_W-1:0] mem_q [DEPTH];

    always_ff @(posedge clock) begin
        if (wr_en) begin
            mem_q[wr_addr] <= wr_data;
        end
    end

    assign rd_data_a = mem_q[rd_addr_a];
    assign rd_data_b = mem_q[rd_addr_b];
endmodule

// File: rtl/cpu_op_sequencer.sv
// Steps a stored opcode program out to the CPU operation/enable port, one code per HOLD_CYCLES.
// Optional macro CPU_OP_SEQ_LOOP_EN: wrap to address 0 at program end and run until reset.
module cpu_op_sequencer
    import cpu_op_pkg::seq_state_e;
    import cpu_op_pkg::IDLE;
    import cpu_op_pkg::RUN;
    import cpu_op_pkg::DONE;
#(
    parameter int DEPTH       = 16,
    parameter int OP_W        = cpu_op_pkg::OP_W,
    parameter int HOLD_CYCLES = 4,
    parameter logic [OP_W-1:0] HALT_OP = cpu_op_pkg::HALT_OP
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     start,
    input  logic                     prog_we,
    input  logic [$clog2(DEPTH)-1:0] prog_addr,
    input  logic [OP_W-1:0]          prog_data,
    output logic [OP_W-1:0]          operation,
    output logic                     enable,
    output logic                     busy,
    output logic                     done,
    output logic [$clog2(DEPTH)-1:0] pc
);
    localparam int AW     = $clog2(DEPTH);
    localparam int HOLD_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
    localparam logic [HOLD_W-1:0] HOLD_RELOAD = HOLD_W'(HOLD_CYCLES - 1);
    localparam logic [AW-1:0]     LAST_ADDR   = AW'(DEPTH - 1);

    seq_state_e        state_q, state_d;
    logic [AW-1:0]     pc_q, pc_d;
    logic [OP_W-1:0]   op_q, op_d;
    logic              en_q, en_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic [HOLD_W-1:0] hold_q, hold_d;

    logic              wr_en;
    logic [AW-1:0]     pc_inc;
    logic [OP_W-1:0]   rd_first;
    logic [OP_W-1:0]   rd_next;
    logic [OP_W-1:0]   first_op;

    assign wr_en  = prog_we && (state_q == IDLE) && !reset;
    assign pc_inc = pc_q + AW'(1);
    // A write landing on address 0 in the start cycle must be seen by that start.
    assign first_op = (wr_en && (prog_addr == '0)) ? prog_data : rd_first;

    cpu_op_prog_mem #(
        .DEPTH (DEPTH),
        .OP_W  (OP_W)
    ) u_prog_mem (
        .clock     (clock),
        .wr_en     (wr_en),
        .wr_addr   (prog_addr),
        .wr_data   (prog_data),
        .rd_addr_a ('0),
        .rd_data_a (rd_first),
        .rd_addr_b (pc_inc),
        .rd_data_b (rd_next)
    );

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        op_d    = op_q;
        en_d    = 1'b0;
        busy_d  = busy_q;
        done_d  = 1'b0;
        hold_d  = hold_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    pc_d = '0;
                    if (first_op == HALT_OP) begin
                        state_d = DONE;
                        done_d  = 1'b1;
                        op_d    = '0;
`ifdef CPU_OP_SEQ_LOOP_EN
                        busy_d  = 1'b1;
`endif
                    end else begin
                        state_d = RUN;
                        op_d    = first_op;
                        en_d    = 1'b1;
                        busy_d  = 1'b1;
                        hold_d  = HOLD_RELOAD;
                    end
                end
            end
            RUN: begin
                if (hold_q != '0) begin
                    hold_d = hold_q - HOLD_W'(1);
`ifdef CPU_OP_SEQ_LOOP_EN
                end else if ((pc_q == LAST_ADDR) || (rd_next == HALT_OP)) begin
                    done_d = 1'b1;
                    pc_d   = '0;
                    if (first_op == HALT_OP) begin
                        state_d = DONE;
                        op_d    = '0;
                    end else begin
                        op_d   = first_op;
                        en_d   = 1'b1;
                        hold_d = HOLD_RELOAD;
                    end
`else
                end else if (pc_q == LAST_ADDR) begin
                    state_d = DONE;
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                    op_d    = '0;
                end else if (rd_next == HALT_OP) begin
                    state_d = DONE;
                    pc_d    = pc_inc;
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                    op_d    = '0;
`endif
                end else begin
                    pc_d   = pc_inc;
                    op_d   = rd_next;
                    en_d   = 1'b1;
                    hold_d = HOLD_RELOAD;
                end
            end
            DONE: begin
`ifdef CPU_OP_SEQ_LOOP_EN
                // Address 0 holds HALT and memory is frozen while busy: pulse forever.
                done_d = 1'b1;
`else
                state_d = IDLE;
                busy_d  = 1'b0;
                op_d    = '0;
`endif
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= IDLE;
            pc_q    <= '0;
            op_q    <= '0;
            en_q    <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            hold_q  <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            op_q    <= op_d;
            en_q    <= en_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            hold_q  <= hold_d;
        end
    end

    assign operation = op_q;
    assign enable    = en_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign pc        = pc_q;
endmodule

// File: tb/tb_cpu_op_sequencer.sv
// Self-checking bench: two sequencers (HOLD_CYCLES 4 and 1) against a program-level expectation model.
module tb_cpu_op_sequencer;
    localparam int DEPTH = 16;
    localparam logic [3:0] HALT = 4'hF;

    typedef struct packed {
        logic [3:0] op;
        logic       en;
        logic       busy;
        logic       done;
        logic [3:0] pc;
    } obs_t;

    logic       clock = 1'b0;
    logic       reset, start, prog_we;
    logic [3:0] prog_addr, prog_data;

    logic [3:0] op_h4, pc_h4, op_h1, pc_h1;
    logic       en_h4, busy_h4, done_h4, en_h1, busy_h1, done_h1;
    obs_t       act [2];

    int n_cmp  = 0;
    int n_fail = 0;
    bit cmp_on = 1'b0;

    // Expectation model: per-instance memory image and precomputed output timeline.
    logic [3:0] mmem [2][DEPTH];
    obs_t       mbuf [2][512];
    int         mhead [2];
    int         mtail [2];
    obs_t       cur_exp [2];
    int         hold_of [2] = '{4, 1};

    always #5 clock = ~clock;

    cpu_op_sequencer #(.DEPTH(DEPTH), .OP_W(4), .HOLD_CYCLES(4), .HALT_OP(HALT)) dut_h4 (
        .clock(clock), .reset(reset), .start(start), .prog_we(prog_we),
        .prog_addr(prog_addr), .prog_data(prog_data),
        .operation(op_h4), .enable(en_h4), .busy(busy_h4), .done(done_h4), .pc(pc_h4)
    );

    cpu_op_sequencer #(.DEPTH(DEPTH), .OP_W(4), .HOLD_CYCLES(1), .HALT_OP(HALT)) dut_h1 (
        .clock(clock), .reset(reset), .start(start), .prog_we(prog_we),
        .prog_addr(prog_addr), .prog_data(prog_data),
        .operation(op_h1), .enable(en_h1), .busy(busy_h1), .done(done_h1), .pc(pc_h1)
    );

    assign act[0] = {op_h4, en_h4, busy_h4, done_h4, pc_h4};
    assign act[1] = {op_h1, en_h1, busy_h1, done_h1, pc_h1};

    task automatic push(int k, logic [3:0] op, logic en, logic b, logic d, logic [3:0] p);
        obs_t e;
        e.op = op; e.en = en; e.busy = b; e.done = d; e.pc = p;
        mbuf[k][mtail[k]] = e;
        mtail[k]++;
    endtask

    // Whole-run timeline from the program image: each op shown for hold cycles, enable on the first.
    task automatic build_run(int k);
        int a;
        int h;
        bit stop;
        mhead[k] = 0;
        mtail[k] = 0;
        h = hold_of[k];
        a = 0;
        stop = 1'b0;
`ifdef CPU_OP_SEQ_LOOP_EN
        begin
            bit pend;
            pend = 1'b0;
            while (mtail[k] < 300) begin
                if (mmem[k][a] == HALT) begin
                    push(k, 4'h0, 1'b0, 1'b1, 1'b1, 4'h0);
                end else begin
                    for (int i = 0; i < h; i++)
                        push(k, mmem[k][a], i == 0, 1'b1, (i == 0) && pend, a[3:0]);
                    pend = 1'b0;
                    if (a == DEPTH - 1 || mmem[k][a + 1] == HALT) begin
                        a = 0;
                        pend = 1'b1;
                    end else begin
                        a++;
                    end
                end
            end
        end
`else
        while (!stop) begin
            if (mmem[k][a] == HALT) begin
                stop = 1'b1;
            end else begin
                for (int i = 0; i < h; i++)
                    push(k, mmem[k][a], i == 0, 1'b1, 1'b0, a[3:0]);
                if (a == DEPTH - 1) stop = 1'b1;
                else a++;
            end
        end
        push(k, 4'h0, 1'b0, 1'b0, 1'b1, a[3:0]);
`endif
    endtask

    task automatic model_edge(int k);
        if (reset) begin
            mhead[k] = 0;
            mtail[k] = 0;
            cur_exp[k] = '0;
        end else if (mhead[k] < mtail[k]) begin
            cur_exp[k] = mbuf[k][mhead[k]];
            mhead[k]++;
        end else if (cur_exp[k].done) begin
            cur_exp[k].done = 1'b0;
            cur_exp[k].busy = 1'b0;
            cur_exp[k].en   = 1'b0;
            cur_exp[k].op   = 4'h0;
        end else begin
            if (prog_we) mmem[k][prog_addr] = prog_data;
            if (start) begin
                build_run(k);
                cur_exp[k] = mbuf[k][0];
                mhead[k] = 1;
            end
        end
    endtask

    initial forever begin
        @(posedge clock);
        model_edge(0);
        model_edge(1);
    end

    initial forever begin
        @(negedge clock);
        if (cmp_on) begin
            for (int k = 0; k < 2; k++) begin
                n_cmp++;
                if (act[k] !== cur_exp[k]) begin
                    n_fail++;
                    $display("FAIL cycle_h%0d @%0t: got op=%h en=%b busy=%b done=%b pc=%0d want op=%h en=%b busy=%b done=%b pc=%0d",
                             hold_of[k], $time, act[k].op, act[k].en, act[k].busy, act[k].done, act[k].pc,
                             cur_exp[k].op, cur_exp[k].en, cur_exp[k].busy, cur_exp[k].done, cur_exp[k].pc);
                end
            end
        end
    end

    task automatic lit(string name, logic [31:0] got, logic [31:0] want);
        n_cmp++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got %0h want %0h", name, got, want);
        end
    endtask

    task automatic tick(int n = 1);
        repeat (n) @(negedge clock);
    endtask

    task automatic write_prog(int a, logic [3:0] d);
        prog_we = 1'b1;
        prog_addr = a[3:0];
        prog_data = d;
        tick();
        prog_we = 1'b0;
    endtask

    // Pulse start; returns at the negedge of cycle 1 (first cycle after start is sampled).
    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic pulse_reset();
        reset = 1'b1;
        tick();
        reset = 1'b0;
    endtask

    task automatic wait_idle(int budget);
        int c;
        c = 0;
        while ((busy_h4 || done_h4 || busy_h1 || done_h1) && c < budget) begin
            tick();
            c++;
        end
        tick();
        lit("wait_idle_budget", 32'(c < budget), 32'd1);
    endtask

    initial begin
        logic [3:0] saved [DEPTH];
        reset = 1'b1; start = 1'b0; prog_we = 1'b0; prog_addr = '0; prog_data = '0;
        tick(3);
        cmp_on = 1'b1;
        lit("reset_op", 32'(op_h4), 32'h0);
        lit("reset_busy", 32'(busy_h4), 32'h0);
        lit("reset_pc", 32'(pc_h4), 32'h0);
        reset = 1'b0;
        for (int a = 0; a < DEPTH; a++) write_prog(a, 4'h0);

`ifndef CPU_OP_SEQ_LOOP_EN
        write_prog(0, 4'h3); write_prog(1, 4'h5); write_prog(2, 4'hA); write_prog(3, 4'hF);
        pulse_start();
        lit("t1_c1_en", 32'(en_h4), 32'h1);
        lit("t1_c1_op", 32'(op_h4), 32'h3);
        tick(4);
        lit("t1_c5_op_en", {op_h4, en_h4}, {4'h5, 1'b1});
        tick(4);
        lit("t1_c9_op_en", {op_h4, en_h4}, {4'hA, 1'b1});
        tick(4);
        lit("t1_c13_done_pc_busy", {done_h4, pc_h4, busy_h4}, {1'b1, 4'h3, 1'b0});
        wait_idle(100);

        write_prog(0, 4'hF);
        pulse_start();
        lit("t2_c1_done_en_op", {done_h4, en_h4, op_h4}, {1'b1, 1'b0, 4'h0});
        wait_idle(100);

        for (int a = 0; a < DEPTH; a++) begin
            saved[a] = 4'($urandom_range(0, 14));
            write_prog(a, saved[a]);
        end
        pulse_start();
        tick(15);
        lit("t3_c16_op_en", {op_h1, en_h1, pc_h1}, {saved[15], 1'b1, 4'hF});
        tick();
        lit("t3_c17_done_pc", {done_h1, pc_h1}, {1'b1, 4'hF});
        tick(2);
        start = 1'b1; prog_we = 1'b1; prog_addr = 4'h5; prog_data = 4'hF;
        tick();
        start = 1'b0; prog_we = 1'b0;
        wait_idle(200);
        pulse_start();
        tick(20);
        lit("t4_mem_kept_op", {op_h4, en_h4}, {saved[5], 1'b1});
        wait_idle(200);

        prog_we = 1'b1; prog_addr = 4'h0; prog_data = 4'h7;
        pulse_start();
        prog_we = 1'b0;
        lit("t5_write_start_op", {op_h4, en_h4}, {4'h7, 1'b1});
        wait_idle(200);

        write_prog(0, 4'h3); write_prog(1, 4'h5); write_prog(2, 4'hA); write_prog(3, 4'hF);
        pulse_start();
        tick(4);
        pulse_reset();
        lit("t6_reset_mid", {op_h4, en_h4, busy_h4, pc_h4}, 10'h0);
        pulse_start();
        lit("t6_replay_op", {op_h4, en_h4}, {4'h3, 1'b1});
        wait_idle(100);
`else
        write_prog(0, 4'h2); write_prog(1, 4'hF);
        pulse_start();
        lit("loop_c1", {op_h4, en_h4, done_h4}, {4'h2, 1'b1, 1'b0});
        tick(4);
        lit("loop_c5", {op_h4, en_h4, done_h4, busy_h4}, {4'h2, 1'b1, 1'b1, 1'b1});
        tick(4);
        lit("loop_c9", {op_h4, en_h4, done_h4, busy_h4}, {4'h2, 1'b1, 1'b1, 1'b1});
        tick(20);
        lit("loop_busy_kept", 32'(busy_h4), 32'h1);
        pulse_reset();
        lit("loop_reset", {op_h4, en_h4, busy_h4, pc_h4}, 10'h0);
        write_prog(0, 4'hF);
        pulse_start();
        tick(3);
        lit("loop_allhalt", {done_h1, en_h1, busy_h1}, {1'b1, 1'b0, 1'b1});
        pulse_reset();
`endif

        for (int it = 0; it < 16; it++) begin
            int rst_at;
            for (int a = 0; a < DEPTH; a++)
                write_prog(a, ($urandom_range(0, 4) == 0) ? 4'hF : 4'($urandom_range(0, 14)));
            rst_at = ($urandom_range(0, 2) == 0) ? int'($urandom_range(5, 60)) : -1;
            prog_we = ($urandom_range(0, 1) == 1);
            prog_addr = 4'($urandom_range(0, 15));
            prog_data = 4'($urandom_range(0, 15));
            pulse_start();
            prog_we = 1'b0;
            for (int c = 0; c < 80; c++) begin
                start = ($urandom_range(0, 15) == 0);
                prog_we = ($urandom_range(0, 7) == 0);
                prog_addr = 4'($urandom_range(0, 15));
                prog_data = 4'($urandom_range(0, 15));
                reset = (c == rst_at);
                tick();
            end
            start = 1'b0; prog_we = 1'b0; reset = 1'b0;
`ifdef CPU_OP_SEQ_LOOP_EN
            pulse_reset();
`else
            wait_idle(200);
`endif
        end

        cmp_on = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, compared %0d", n_cmp);
        $fatal(1, "watchdog");
    end
endmodule
